// File: rtl/bs_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer.
package bs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    MULT = 2'd2,
    DONE = 2'd3
  } bs_state_t;

  localparam logic BS_OP_ADD  = 1'b0;
  localparam logic BS_OP_MULT = 1'b1;

endpackage

// File: rtl/adder.sv
// One-bit full adder cell; the only arithmetic element of the bit-serial ALU.
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bs_alu_seq.sv
// Bit-serial add/multiply sequencer driving a single shared full-adder cell.
// Define BS_MULT_EN to build the multiply path; otherwise multiply requests report unsupported.
module bs_alu_seq
  import bs_pkg::*;
#(
  parameter int unsigned length = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_con_alufun,
  input  logic [length-1:0] i_data_a,
  input  logic [length-1:0] i_data_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [length-1:0] o_data_result,
  output logic              o_flag
);

  localparam int unsigned CW = (length > 1) ? $clog2(length) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(length - 1);

  bs_state_t         state_q, state_d;
  logic [length-1:0] a_q, a_d;
  logic [length-1:0] b_q, b_d;
  logic [length-1:0] acc_q, acc_d;
  logic [CW-1:0]     k_q, k_d;
  logic              carry_q, carry_d;
  logic              busy_d, done_d, flag_d;
  logic [length-1:0] result_d;

  logic              add_a, add_b, add_sum, add_cout;
  logic              k_last;
  logic [CW-1:0]     k_inc;

`ifdef BS_MULT_EN
  logic [CW-1:0]     j_q, j_d;
  logic              sticky_q, sticky_d;
  logic              pp_bit;
  logic              shifted_out;

  // Partial-product bit for (A << j) at position k, and A bits pushed past the MSB by that shift.
  always_comb begin
    pp_bit      = 1'b0;
    shifted_out = 1'b0;
    if (k_q >= j_q) pp_bit = a_q[k_q - j_q];
    for (int unsigned i = 0; i < length; i++) begin
      if (i + 32'(j_q) >= length) shifted_out = shifted_out | a_q[i];
    end
  end
`endif

  // Adder operand selection; kept apart from the next-state logic so no comb loop is formed.
  always_comb begin
    add_a = 1'b0;
    add_b = 1'b0;
    case (state_q)
      ADD: begin
        add_a = a_q[k_q];
        add_b = b_q[k_q];
      end
`ifdef BS_MULT_EN
      MULT: begin
        add_a = acc_q[0];
        add_b = b_q[j_q] & pp_bit;
      end
`endif
      default: ;
    endcase
  end

  adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign k_last = (k_q == K_LAST);
  assign k_inc  = k_last ? '0 : k_q + CW'(1);

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    k_d      = k_q;
    carry_d  = carry_q;
    busy_d   = o_busy;
    done_d   = 1'b0;
    result_d = o_data_result;
    flag_d   = o_flag;
`ifdef BS_MULT_EN
    j_d      = j_q;
    sticky_d = sticky_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d     = i_data_a;
          b_d     = i_data_b;
          acc_d   = '0;
          k_d     = '0;
          carry_d = 1'b0;
          busy_d  = 1'b1;
`ifdef BS_MULT_EN
          j_d      = '0;
          sticky_d = 1'b0;
`endif
          if (i_con_alufun == BS_OP_MULT) begin
`ifdef BS_MULT_EN
            state_d = MULT;
`else
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = '0;
            flag_d   = 1'b1;
`endif
          end else begin
            state_d = ADD;
          end
        end
      end

      ADD: begin
        acc_d   = {add_sum, acc_q[length-1:1]};
        carry_d = add_cout;
        k_d     = k_inc;
        if (k_last) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = acc_d;
          flag_d   = add_cout;
        end
      end

`ifdef BS_MULT_EN
      // Each pass rotates the accumulator once while adding the shifted, gated multiplicand.
      MULT: begin
        acc_d    = {add_sum, acc_q[length-1:1]};
        carry_d  = k_last ? 1'b0 : add_cout;
        sticky_d = sticky_q | (k_last & add_cout)
                 | ((k_q == '0) & b_q[j_q] & shifted_out);
        k_d      = k_inc;
        if (k_last) begin
          if (j_q == K_LAST) begin
            j_d      = '0;
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = acc_d;
            flag_d   = sticky_d;
          end else begin
            j_d = j_q + CW'(1);
          end
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      k_q           <= '0;
      carry_q       <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_data_result <= '0;
      o_flag        <= 1'b0;
`ifdef BS_MULT_EN
      j_q           <= '0;
      sticky_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      acc_q         <= acc_d;
      k_q           <= k_d;
      carry_q       <= carry_d;
      o_busy        <= busy_d;
      o_done        <= done_d;
      o_data_result <= result_d;
      o_flag        <= flag_d;
`ifdef BS_MULT_EN
      j_q           <= j_d;
      sticky_q      <= sticky_d;
`endif
    end
  end

endmodule
